intdivpreprocfsm: RTL and testbench

Issue-side companion to the divide/sqrt postprocessor for integer divide and remainder. It accepts an integer divide from the Execute stage and computes operand signs, magnitudes, leading-zero counts, and special-case flags (divide-by-zero, |A|<|B|). It runs the iteration-count state machine that keeps the divider busy for the required number of cycles. It then delivers the Memory-stage control fields the postprocessor consumes: AM, AsM, BsM, RemOpM, W64M, ALTBM, BZeroM, IntNormShiftM.

---
 rtl/intdivpreprocfsm.sv | 221 ++++++++++++++++++++++
 tb/tb_intdivpreprocfsm.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdivpreprocfsm.sv
// intdivpreprocfsm
//
// Issue-side front end for integer divide and remainder. It takes an integer
// divide from Execute, forms operand signs and magnitudes, counts leading
// zeros, flags the divide-by-zero and |A|<|B| shortcuts, and works out how
// many iterations the divider needs. A small FSM keeps the divider busy for
// that many cycles, then hands the Memory-stage control fields to the
// postprocessor.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   IntDivE                 start request (only honoured in IDLE)
//   FlushE                  abort whatever is in flight
//   StallM                  Memory stage stalled; holds DONE and the M fields
//   ForwardedSrcAE/BE       dividend A, divisor B
//   Funct3E                 bit0 = unsigned, bit1 = remainder
//   W64E                    32-bit op on a 64-bit datapath
//   DivBusyE                high while BUSY or DONE
//   DivDoneE                one-cycle pulse on entry to DONE
//   APosE, BPosE            registered |A|, |B| for the iteration datapath
//   CyclesE                 iteration count of the current op
//   AM                      W64-extended dividend, M stage
//   AsM, BsM, RemOpM, W64M,
//   ALTBM, BZeroM           M-stage flags
//   IntNormShiftM           result right shift applied by the postprocessor

module intdivpreprocfsm #(
   parameter int XLEN    = 64,
   parameter int LOGR    = 1,
   parameter int DIVBLEN = $clog2(XLEN+1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               IntDivE,
   input  logic               FlushE,
   input  logic               StallM,
   input  logic [XLEN-1:0]    ForwardedSrcAE,
   input  logic [XLEN-1:0]    ForwardedSrcBE,
   input  logic [2:0]         Funct3E,
   input  logic               W64E,
   output logic               DivBusyE,
   output logic               DivDoneE,
   output logic [XLEN-1:0]    APosE,
   output logic [XLEN-1:0]    BPosE,
   output logic [DIVBLEN-1:0] CyclesE,
   output logic [XLEN-1:0]    AM,
   output logic               AsM,
   output logic               BsM,
   output logic               RemOpM,
   output logic               W64M,
   output logic               ALTBM,
   output logic               BZeroM,
   output logic [DIVBLEN-1:0] IntNormShiftM
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state, nextstate;
   logic [DIVBLEN-1:0] count;

   logic               signedop, w64eff;
   logic [XLEN-1:0]    aext, bext, aprime, bprime, posa, posb;
   logic               as_e, bs_e, bzero_e, altb_e, special_e;
   logic [DIVBLEN-1:0] ma, mb, p, cycles_e, shift_e;
   logic               start, leave;

   logic [XLEN-1:0]    ahold;
   logic               ashold, bshold, remhold, w64hold, altbhold, bzerohold;
   logic [DIVBLEN-1:0] shifthold;

   logic               unused_funct3;
   assign unused_funct3 = Funct3E[2];

   // Leading-zero count; an all-zero word counts as XLEN.
   function automatic logic [DIVBLEN-1:0] lzc(input logic [XLEN-1:0] v);
      logic [DIVBLEN-1:0] n;
      logic               found;
      n     = '0;
      found = 1'b0;
      for (int i = XLEN-1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + DIVBLEN'(1);
         end
      end
      return n;
   endfunction

   assign signedop = ~Funct3E[0];

   // Word ops only exist on a 64-bit datapath; there the low halves are
   // sign- or zero-extended according to signedness.
   if (XLEN == 64) begin : g_w64
      assign w64eff = W64E;
      assign aext   = {{(XLEN-32){signedop & ForwardedSrcAE[31]}}, ForwardedSrcAE[31:0]};
      assign bext   = {{(XLEN-32){signedop & ForwardedSrcBE[31]}}, ForwardedSrcBE[31:0]};
   end else begin : g_w32
      logic unused_w64;
      assign unused_w64 = W64E;
      assign w64eff     = 1'b0;
      assign aext       = ForwardedSrcAE;
      assign bext       = ForwardedSrcBE;
   end

   assign aprime = w64eff ? aext : ForwardedSrcAE;
   assign bprime = w64eff ? bext : ForwardedSrcBE;

   // Magnitudes are unsigned, so the most-negative value becomes 2^(XLEN-1).
   assign as_e = signedop & aprime[XLEN-1];
   assign bs_e = signedop & bprime[XLEN-1];
   assign posa = as_e ? -aprime : aprime;
   assign posb = bs_e ? -bprime : bprime;

   assign ma = lzc(posa);
   assign mb = lzc(posb);

   assign bzero_e   = (bprime == '0);
   assign altb_e    = ~bzero_e & (ma > mb);
   assign special_e = bzero_e | altb_e;

   // p is only meaningful for ops that actually iterate; for shortcut ops
   // the iteration count and shift below are don't-cares.
   assign p        = mb - ma;
   assign cycles_e = p / DIVBLEN'(LOGR) + DIVBLEN'(1);
   assign shift_e  = cycles_e * DIVBLEN'(LOGR) - DIVBLEN'(1) - p;

   assign start = (state == IDLE) & IntDivE & ~FlushE;
   assign leave = (state == DONE) & ~StallM & ~FlushE;

   assign DivBusyE = (state == BUSY) | (state == DONE);

   // Next-state logic. Shortcut ops skip BUSY entirely; a flush always wins
   // and returns to IDLE regardless of what else is happening.
   always_comb begin
      nextstate = state;
      case (state)
         IDLE:    if (IntDivE) nextstate = special_e ? DONE : BUSY;
         BUSY:    if (count == '0) nextstate = DONE;
         DONE:    if (!StallM) nextstate = IDLE;
         default: nextstate = IDLE;
      endcase
      if (FlushE) nextstate = IDLE;
   end

   // State, iteration counter and the done pulse. The counter is loaded with
   // Cycles-1 so BUSY lasts exactly Cycles cycles; the done pulse fires only
   // on the cycle DONE is entered, so a stall in DONE does not repeat it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         DivDoneE <= 1'b0;
      end else begin
         state    <= nextstate;
         DivDoneE <= (nextstate == DONE) & (state != DONE);
         if (FlushE)
            count <= '0;
         else if (start & ~special_e)
            count <= cycles_e - DIVBLEN'(1);
         else if ((state == BUSY) && (count != '0))
            count <= count - DIVBLEN'(1);
      end
   end

   // E-side holding registers, captured once when an op is accepted so the
   // Execute inputs are free to change while the divider runs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         APosE     <= '0;
         BPosE     <= '0;
         CyclesE   <= '0;
         ahold     <= '0;
         ashold    <= 1'b0;
         bshold    <= 1'b0;
         remhold   <= 1'b0;
         w64hold   <= 1'b0;
         altbhold  <= 1'b0;
         bzerohold <= 1'b0;
         shifthold <= '0;
      end else if (start) begin
         APosE     <= posa;
         BPosE     <= posb;
         CyclesE   <= cycles_e;
         ahold     <= aprime;
         ashold    <= as_e;
         bshold    <= bs_e;
         remhold   <= Funct3E[1];
         w64hold   <= w64eff;
         altbhold  <= altb_e;
         bzerohold <= bzero_e;
         shifthold <= shift_e;
      end
   end

   // Memory-stage registers advance only when DONE hands off to an
   // unstalled Memory stage; a flush in that cycle leaves them untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         AM            <= '0;
         AsM           <= 1'b0;
         BsM           <= 1'b0;
         RemOpM        <= 1'b0;
         W64M          <= 1'b0;
         ALTBM         <= 1'b0;
         BZeroM        <= 1'b0;
         IntNormShiftM <= '0;
      end else if (leave) begin
         AM            <= ahold;
         AsM           <= ashold;
         BsM           <= bshold;
         RemOpM        <= remhold;
         W64M          <= w64hold;
         ALTBM         <= altbhold;
         BZeroM        <= bzerohold;
         IntNormShiftM <= shifthold;
      end
   end

endmodule

// File: tb/tb_intdivpreprocfsm.sv
// tb_intdivpreprocfsm
//
// Drives two copies of intdivpreprocfsm (radix 2 and radix 4) with the same
// operations. Expected results come from an arithmetic reference model and
// are queued per instance when an op is issued; one monitor per instance
// pops and compares whenever that instance signals done.

module tb_intdivpreprocfsm;

   localparam int XLEN    = 64;
   localparam int DIVBLEN = 7;

   typedef struct {
      logic [63:0] apos;
      logic [63:0] bpos;
      logic [63:0] am;
      logic [6:0]  cycles;
      logic [6:0]  shift;
      logic        asx;
      logic        bsx;
      logic        rem;
      logic        w64;
      logic        altb;
      logic        bzero;
      int          latency;
      int          issuecyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              intdive, flushe, stallm, w64e;
   logic [XLEN-1:0]   srca, srcb;
   logic [2:0]        funct3;

   logic              dutbusy[2], dutdone[2];
   logic [XLEN-1:0]   dutapos[2], dutbpos[2], dutam[2];
   logic [DIVBLEN-1:0] dutcycles[2], dutshift[2];
   logic              dutas[2], dutbs[2], dutrem[2], dutw64[2], dutaltb[2], dutbzero[2];

   int   checks = 0;
   int   fails  = 0;
   int   cycnt  = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t lastexp[2];

   always #5 clk = ~clk;

   always @(posedge clk) cycnt <= cycnt + 1;

   intdivpreprocfsm #(.XLEN(64), .LOGR(1)) dut0 (
      .clk(clk), .reset(reset), .IntDivE(intdive), .FlushE(flushe), .StallM(stallm),
      .ForwardedSrcAE(srca), .ForwardedSrcBE(srcb), .Funct3E(funct3), .W64E(w64e),
      .DivBusyE(dutbusy[0]), .DivDoneE(dutdone[0]), .APosE(dutapos[0]), .BPosE(dutbpos[0]),
      .CyclesE(dutcycles[0]), .AM(dutam[0]), .AsM(dutas[0]), .BsM(dutbs[0]),
      .RemOpM(dutrem[0]), .W64M(dutw64[0]), .ALTBM(dutaltb[0]), .BZeroM(dutbzero[0]),
      .IntNormShiftM(dutshift[0]));

   intdivpreprocfsm #(.XLEN(64), .LOGR(2)) dut1 (
      .clk(clk), .reset(reset), .IntDivE(intdive), .FlushE(flushe), .StallM(stallm),
      .ForwardedSrcAE(srca), .ForwardedSrcBE(srcb), .Funct3E(funct3), .W64E(w64e),
      .DivBusyE(dutbusy[1]), .DivDoneE(dutdone[1]), .APosE(dutapos[1]), .BPosE(dutbpos[1]),
      .CyclesE(dutcycles[1]), .AM(dutam[1]), .AsM(dutas[1]), .BsM(dutbs[1]),
      .RemOpM(dutrem[1]), .W64M(dutw64[1]), .ALTBM(dutaltb[1]), .BZeroM(dutbzero[1]),
      .IntNormShiftM(dutshift[1]));

   // Number of significant bits in v (0 for v == 0).
   function automatic int bitlen(input logic [63:0] v);
      int n;
      n = 0;
      while (n < 64 && (v >> n) != 64'd0) n++;
      return n;
   endfunction

   // Reference model: what the divider front end should produce for one op
   // at a given radix, worked out from signedness, magnitudes and bit lengths.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] f3, input logic w64,
                                  input int logr, input int issue);
      exp_t        e;
      logic        sgn;
      logic [63:0] ap, bp;
      int          ma, mb, p, cyc;
      sgn = !f3[0];
      ap  = a;
      bp  = b;
      if (w64) begin
         ap = {32'h0, a[31:0]};
         bp = {32'h0, b[31:0]};
         if (sgn && a[31]) ap[63:32] = 32'hFFFF_FFFF;
         if (sgn && b[31]) bp[63:32] = 32'hFFFF_FFFF;
      end
      e.asx     = sgn && ap[63];
      e.bsx     = sgn && bp[63];
      e.apos    = e.asx ? 64'd0 - ap : ap;
      e.bpos    = e.bsx ? 64'd0 - bp : bp;
      e.am      = ap;
      ma        = 64 - bitlen(e.apos);
      mb        = 64 - bitlen(e.bpos);
      e.bzero   = (bp == 64'd0);
      e.altb    = !e.bzero && (ma > mb);
      p         = mb - ma;
      cyc       = p / logr + 1;
      e.cycles  = 7'(cyc);
      e.shift   = 7'(cyc * logr - 1 - p);
      e.latency = (e.bzero || e.altb) ? 1 : cyc + 1;
      e.rem     = f3[1];
      e.w64     = w64;
      e.issuecyc = issue;
      return e;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic checkZero(input string tag);
      for (int k = 0; k < 2; k++) begin
         checkOutput({tag, " busy"},   64'(dutbusy[k]),   64'd0);
         checkOutput({tag, " done"},   64'(dutdone[k]),   64'd0);
         checkOutput({tag, " apos"},   dutapos[k],        64'd0);
         checkOutput({tag, " bpos"},   dutbpos[k],        64'd0);
         checkOutput({tag, " cycles"}, 64'(dutcycles[k]), 64'd0);
         checkOutput({tag, " am"},     dutam[k],          64'd0);
         checkOutput({tag, " flags"},
                     64'({dutas[k], dutbs[k], dutrem[k], dutw64[k], dutaltb[k], dutbzero[k]}), 64'd0);
         checkOutput({tag, " shift"},  64'(dutshift[k]),  64'd0);
      end
   endtask

   // Monitor for instance k: on each done pulse, pop the expectation, check
   // latency and E-side values, ride out any stall, then check the M fields
   // one cycle after the hand-off.
   task automatic monitor(input int k);
      exp_t e;
      int   n;
      forever begin
         @(negedge clk);
         if (dutdone[k]) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
               checkOutput("unexpected done", 64'd1, 64'd0);
            end else begin
               if (k == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               checkOutput("done latency", 64'(cycnt - e.issuecyc), 64'(e.latency));
               checkOutput("APosE", dutapos[k], e.apos);
               checkOutput("BPosE", dutbpos[k], e.bpos);
               if (!(e.bzero || e.altb))
                  checkOutput("CyclesE", 64'(dutcycles[k]), 64'(e.cycles));
               n = 0;
               while (stallm && n < 200) begin
                  @(negedge clk);
                  n++;
                  checkOutput("single done pulse", 64'(dutdone[k]), 64'd0);
                  checkOutput("busy while stalled", 64'(dutbusy[k]), 64'd1);
               end
               if (n >= 200) checkOutput("stall release timeout", 64'd0, 64'd1);
               @(negedge clk);
               checkOutput("AM",     dutam[k],          e.am);
               checkOutput("AsM",    64'(dutas[k]),     64'(e.asx));
               checkOutput("BsM",    64'(dutbs[k]),     64'(e.bsx));
               checkOutput("RemOpM", 64'(dutrem[k]),    64'(e.rem));
               checkOutput("W64M",   64'(dutw64[k]),    64'(e.w64));
               checkOutput("ALTBM",  64'(dutaltb[k]),   64'(e.altb));
               checkOutput("BZeroM", 64'(dutbzero[k]),  64'(e.bzero));
               if (!(e.bzero || e.altb))
                  checkOutput("IntNormShiftM", 64'(dutshift[k]), 64'(e.shift));
               checkOutput("idle after hand-off", 64'(dutbusy[k]), 64'd0);
               lastexp[k] = e;
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic waitIdle();
      int n;
      n = 0;
      while ((dutbusy[0] || dutbusy[1]) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) checkOutput("idle timeout", 64'd0, 64'd1);
   endtask

   // Issue one op, queue its expectations, optionally stall the Memory stage
   // for 'stall' cycles of DONE, then wait for both instances to go idle.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [2:0] f3, input logic w64, input int stall);
      int n;
      @(posedge clk); #1;
      srca    = a;
      srcb    = b;
      funct3  = f3;
      w64e    = w64;
      intdive = 1'b1;
      stallm  = (stall > 0);
      q0.push_back(model(a, b, f3, w64, 1, cycnt));
      q1.push_back(model(a, b, f3, w64, 2, cycnt));
      @(posedge clk); #1;
      intdive = 1'b0;
      if (stall > 0) begin
         n = 0;
         while (!dutdone[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 200) checkOutput("done timeout", 64'd0, 64'd1);
         repeat (stall - 1) begin
            @(posedge clk); #1;
         end
         stallm = 1'b0;
      end
      waitIdle();
   endtask

   // Start a long op and flush it on its third BUSY cycle.
   task automatic flushBusy();
      @(posedge clk); #1;
      srca    = 64'h0000_0100_0000_0000;
      srcb    = 64'd3;
      funct3  = 3'b001;
      w64e    = 1'b0;
      intdive = 1'b1;
      @(posedge clk); #1;
      intdive = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      flushe = 1'b1;
      @(posedge clk); #1;
      flushe = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checkOutput("flush busy drop",  64'(dutbusy[k]),  64'd0);
         checkOutput("flush no done",    64'(dutdone[k]),  64'd0);
         checkOutput("flush AM held",    dutam[k],         lastexp[k].am);
         checkOutput("flush RemOpM held", 64'(dutrem[k]),  64'(lastexp[k].rem));
         checkOutput("flush shift held", 64'(dutshift[k]), 64'(lastexp[k].shift));
      end
   endtask

   initial begin
      logic [63:0] ra, rb;
      reset   = 1'b1;
      intdive = 1'b0;
      flushe  = 1'b0;
      stallm  = 1'b0;
      w64e    = 1'b0;
      srca    = '0;
      srcb    = '0;
      funct3  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkZero("reset");
      reset = 1'b0;

      applyStimulus(64'd100, 64'd7, 3'b001, 1'b0, 0);
      applyStimulus(64'h1234, 64'd0, 3'b010, 1'b0, 0);
      applyStimulus(64'd3, 64'd10, 3'b001, 1'b0, 0);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b000, 1'b0, 0);
      applyStimulus(64'h8000_0000_0000_0000, 64'd1, 3'b000, 1'b0, 0);
      applyStimulus(64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0002, 3'b000, 1'b1, 0);
      applyStimulus(64'd100, 64'd7, 3'b001, 1'b0, 4);

      flushBusy();

      // Flush and start together in IDLE: the start must be dropped.
      @(posedge clk); #1;
      intdive = 1'b1;
      flushe  = 1'b1;
      @(posedge clk); #1;
      intdive = 1'b0;
      flushe  = 1'b0;
      for (int k = 0; k < 2; k++)
         checkOutput("flush beats start", 64'(dutbusy[k]), 64'd0);

      // Asynchronous reset in the middle of a BUSY period.
      @(posedge clk); #1;
      srca    = 64'h0000_0100_0000_0000;
      srcb    = 64'd3;
      funct3  = 3'b001;
      w64e    = 1'b0;
      intdive = 1'b1;
      @(posedge clk); #1;
      intdive = 1'b0;
      @(posedge clk); #3;
      checkOutput("busy before reset", 64'(dutbusy[0]), 64'd1);
      reset = 1'b1;
      #1;
      checkZero("async reset");
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 40; i++) begin
         ra = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) ra = ~ra;
         if ($urandom_range(0, 9) == 0) rb = 64'd0;
         else                          rb = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 4) == 0) rb = ~rb;
         applyStimulus(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)));
      end

      repeat (4) @(posedge clk);
      checkOutput("queue0 drained", 64'(q0.size()), 64'd0);
      checkOutput("queue1 drained", 64'(q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
